// File: rtl/pc_next_unit.sv
// Program-counter register and next-PC selector for the MIPS datapath.
// Forms sequential, branch, J/JAL and JR targets; honours fetch handshake and hazard stall.
module pc_next_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             imem_ready,
  input  logic             branch_taken,
  input  logic [31:0]      branch_offset_sh,
  input  logic             jump,
  input  logic [25:0]      jump_index,
  input  logic             jump_reg,
  input  logic [31:0]      reg_target,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic             pc_valid,
  output logic             misaligned,
  output logic [CNT_W-1:0] redirect_cnt
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t      state;
  logic        advance;
  logic        redirect;
  logic        jr_misaligned;
  logic [31:0] next_pc;

  assign pc_plus4 = pc + 32'd4;
  assign advance  = ((state == RUN) || (state == WAIT)) && imem_ready && !stall;

  // Priority: jump_reg > jump > branch_taken > sequential.
  always_comb begin
    // NOTE: every signal gets a default before the if-chain so no path leaves it unassigned, which would infer a latch.
    next_pc       = pc_plus4;
    redirect      = 1'b0;
    jr_misaligned = 1'b0;
    if (jump_reg) begin
      if (reg_target[1:0] != 2'b00) begin
        jr_misaligned = 1'b1;
        next_pc       = pc;
      end else begin
        next_pc  = reg_target;
        redirect = 1'b1;
      end
    end else if (jump) begin
      next_pc  = {pc_plus4[31:28], jump_index, 2'b00};
      redirect = 1'b1;
    end else if (branch_taken) begin
      next_pc  = pc_plus4 + branch_offset_sh;
      redirect = 1'b1;
    end
  end

  // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= BOOT;
      pc           <= RESET_PC;
      pc_valid     <= 1'b0;
      misaligned   <= 1'b0;
      redirect_cnt <= '0;
    end else begin
      misaligned <= 1'b0;
      case (state)
        BOOT: begin
          state    <= RUN;
          pc_valid <= 1'b1;
        end
        RUN:  if (!imem_ready) state <= WAIT;
        WAIT: if (imem_ready)  state <= RUN;
        default: begin
          state    <= BOOT;
          pc_valid <= 1'b0;
        end
      endcase
      if (advance) begin
        pc         <= next_pc;
        misaligned <= jr_misaligned;
        if (redirect && (redirect_cnt != '1))
          redirect_cnt <= redirect_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pc_next_unit.sv
// Self-checking bench for pc_next_unit: scenario tasks with a push/pop scoreboard.
// A second instance with a 2-bit counter exercises saturation on the same stimulus.
module tb_pc_next_unit;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        imem_ready;
  logic        branch_taken;
  logic [31:0] branch_offset_sh;
  logic        jump;
  logic [25:0] jump_index;
  logic        jump_reg;
  logic [31:0] reg_target;

  logic [31:0] pc, pc_plus4, pc_s, pc_plus4_s;
  logic        pc_valid, misaligned, pc_valid_s, misaligned_s;
  logic [15:0] redirect_cnt;
  logic [1:0]  redirect_cnt_s;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        valid;
    logic        mis;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
  } obs_t;

  typedef struct packed {
    logic        rst;
    logic        stall;
    logic        rdy;
    logic        br;
    logic [31:0] off;
    logic        j;
    logic [25:0] ji;
    logic        jr;
    logic [31:0] tgt;
  } stim_t;

  obs_t sb[$];

  pc_next_unit #(.RESET_PC(32'h0000_0000), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .stall(stall), .imem_ready(imem_ready),
    .branch_taken(branch_taken), .branch_offset_sh(branch_offset_sh),
    .jump(jump), .jump_index(jump_index), .jump_reg(jump_reg), .reg_target(reg_target),
    .pc(pc), .pc_plus4(pc_plus4), .pc_valid(pc_valid), .misaligned(misaligned),
    .redirect_cnt(redirect_cnt)
  );

  pc_next_unit #(.RESET_PC(32'h0000_0000), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .stall(stall), .imem_ready(imem_ready),
    .branch_taken(branch_taken), .branch_offset_sh(branch_offset_sh),
    .jump(jump), .jump_index(jump_index), .jump_reg(jump_reg), .reg_target(reg_target),
    .pc(pc_s), .pc_plus4(pc_plus4_s), .pc_valid(pc_valid_s), .misaligned(misaligned_s),
    .redirect_cnt(redirect_cnt_s)
  );

  always #5 clk = ~clk;

  function automatic stim_t idle();
    stim_t s;
    s     = '0;
    s.rdy = 1'b1;
    return s;
  endfunction

  function automatic obs_t mk(input logic [31:0] p, input logic v, input logic m, input int c);
    obs_t o;
    o.pc    = p;
    o.pc4   = p + 32'd4;
    o.valid = v;
    o.mis   = m;
    o.cnt   = 16'(c);
    o.cnt2  = (c >= 3) ? 2'd3 : 2'(c);
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.pc    = pc;
    o.pc4   = pc_plus4;
    o.valid = pc_valid;
    o.mis   = misaligned;
    o.cnt   = redirect_cnt;
    o.cnt2  = redirect_cnt_s;
    return o;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("pc=%h pc4=%h valid=%b mis=%b cnt=%0d cnt2=%0d",
                     o.pc, o.pc4, o.valid, o.mis, o.cnt, o.cnt2);
  endfunction

  task automatic apply(input stim_t s);
    rst              = s.rst;
    stall            = s.stall;
    imem_ready       = s.rdy;
    branch_taken     = s.br;
    branch_offset_sh = s.off;
    jump             = s.j;
    jump_index       = s.ji;
    jump_reg         = s.jr;
    reg_target       = s.tgt;
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    stim_t st[$];
    obs_t  ex[$];
    obs_t  g, e;
    stim_t s;
    s = idle(); s.rst = 1'b1;
    st.push_back(s); ex.push_back(mk(32'h0, 1'b0, 1'b0, 0));
    // BOOT cycle, then sequential fetch 0,4,8,12,16.
    for (int i = 0; i < 5; i++) begin
      st.push_back(idle()); ex.push_back(mk(32'(4 * i), 1'b1, 1'b0, 0));
    end
    foreach (st[i]) begin
      apply(st[i]);
      sb.push_back(ex[i]);
      cyc();
      g = sample();
      e = sb.pop_front();
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL reset_seq step %0d: got %s expected %s", i, fmt(g), fmt(e));
      end
    end
  endtask

  task automatic test_branch();
    stim_t st[$];
    obs_t  ex[$];
    obs_t  g, e;
    stim_t s;
    s = idle(); s.br = 1'b1; s.off = 32'hFFFF_FFF8;
    st.push_back(s); ex.push_back(mk(32'h0000_000C, 1'b1, 1'b0, 1));
    st.push_back(idle()); ex.push_back(mk(32'h0000_0010, 1'b1, 1'b0, 1));
    s = idle(); s.br = 1'b1; s.off = 32'h0000_0040;
    st.push_back(s); ex.push_back(mk(32'h0000_0054, 1'b1, 1'b0, 2));
    foreach (st[i]) begin
      apply(st[i]);
      sb.push_back(ex[i]);
      cyc();
      g = sample();
      e = sb.pop_front();
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL branch step %0d: got %s expected %s", i, fmt(g), fmt(e));
      end
    end
  endtask

  task automatic test_jump_priority();
    stim_t st[$];
    obs_t  ex[$];
    obs_t  g, e;
    stim_t s;
    s = idle(); s.jr = 1'b1; s.tgt = 32'h1000_0020;
    st.push_back(s); ex.push_back(mk(32'h1000_0020, 1'b1, 1'b0, 3));
    s = idle(); s.j = 1'b1; s.ji = 26'h000_0100; s.br = 1'b1; s.off = 32'h0000_0040;
    st.push_back(s); ex.push_back(mk(32'h1000_0400, 1'b1, 1'b0, 4));
    foreach (st[i]) begin
      apply(st[i]);
      sb.push_back(ex[i]);
      cyc();
      g = sample();
      e = sb.pop_front();
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL jump_priority step %0d: got %s expected %s", i, fmt(g), fmt(e));
      end
    end
  endtask

  task automatic test_jr_misaligned();
    stim_t st[$];
    obs_t  ex[$];
    obs_t  g, e;
    stim_t s;
    s = idle(); s.jr = 1'b1; s.j = 1'b1; s.ji = 26'h3; s.tgt = 32'h0000_0102;
    st.push_back(s); ex.push_back(mk(32'h1000_0400, 1'b1, 1'b1, 4));
    st.push_back(idle()); ex.push_back(mk(32'h1000_0404, 1'b1, 1'b0, 4));
    s = idle(); s.jr = 1'b1; s.j = 1'b1; s.br = 1'b1; s.off = 32'h10; s.tgt = 32'h0000_0200;
    st.push_back(s); ex.push_back(mk(32'h0000_0200, 1'b1, 1'b0, 5));
    foreach (st[i]) begin
      apply(st[i]);
      sb.push_back(ex[i]);
      cyc();
      g = sample();
      e = sb.pop_front();
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL jr_misaligned step %0d: got %s expected %s", i, fmt(g), fmt(e));
      end
    end
  endtask

  task automatic test_stall_wait();
    stim_t st[$];
    obs_t  ex[$];
    obs_t  g, e;
    stim_t s;
    for (int i = 0; i < 3; i++) begin
      s = idle(); s.stall = 1'b1; s.br = 1'b1; s.off = 32'h40;
      st.push_back(s); ex.push_back(mk(32'h0000_0200, 1'b1, 1'b0, 5));
    end
    // A misaligned JR under stall is not sampled, so no pulse.
    s = idle(); s.stall = 1'b1; s.jr = 1'b1; s.tgt = 32'h0000_0102;
    st.push_back(s); ex.push_back(mk(32'h0000_0200, 1'b1, 1'b0, 5));
    st.push_back(idle()); ex.push_back(mk(32'h0000_0204, 1'b1, 1'b0, 5));
    s = idle(); s.rdy = 1'b0;
    st.push_back(s); ex.push_back(mk(32'h0000_0204, 1'b1, 1'b0, 5));
    s = idle(); s.rdy = 1'b0; s.br = 1'b1; s.off = 32'h40;
    st.push_back(s); ex.push_back(mk(32'h0000_0204, 1'b1, 1'b0, 5));
    st.push_back(idle()); ex.push_back(mk(32'h0000_0208, 1'b1, 1'b0, 5));
    foreach (st[i]) begin
      apply(st[i]);
      sb.push_back(ex[i]);
      cyc();
      g = sample();
      e = sb.pop_front();
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL stall_wait step %0d: got %s expected %s", i, fmt(g), fmt(e));
      end
    end
  endtask

  task automatic test_wrap();
    stim_t st[$];
    obs_t  ex[$];
    obs_t  g, e;
    stim_t s;
    s = idle(); s.jr = 1'b1; s.tgt = 32'hFFFF_FFFC;
    st.push_back(s); ex.push_back(mk(32'hFFFF_FFFC, 1'b1, 1'b0, 6));
    st.push_back(idle()); ex.push_back(mk(32'h0000_0000, 1'b1, 1'b0, 6));
    s = idle(); s.br = 1'b1; s.off = 32'hFFFF_FFF0;
    st.push_back(s); ex.push_back(mk(32'hFFFF_FFF4, 1'b1, 1'b0, 7));
    foreach (st[i]) begin
      apply(st[i]);
      sb.push_back(ex[i]);
      cyc();
      g = sample();
      e = sb.pop_front();
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL wrap step %0d: got %s expected %s", i, fmt(g), fmt(e));
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    stim_t st[$];
    obs_t  ex[$];
    obs_t  g, e;
    stim_t s;
    s = idle(); s.rdy = 1'b0;
    st.push_back(s); ex.push_back(mk(32'hFFFF_FFF4, 1'b1, 1'b0, 7));
    s = idle(); s.rst = 1'b1; s.rdy = 1'b0; s.jr = 1'b1; s.tgt = 32'h0000_0300;
    st.push_back(s); ex.push_back(mk(32'h0000_0000, 1'b0, 1'b0, 0));
    s = idle(); s.jr = 1'b1; s.tgt = 32'h0000_0300;
    st.push_back(s); ex.push_back(mk(32'h0000_0000, 1'b1, 1'b0, 0));
    st.push_back(idle()); ex.push_back(mk(32'h0000_0004, 1'b1, 1'b0, 0));
    foreach (st[i]) begin
      apply(st[i]);
      sb.push_back(ex[i]);
      cyc();
      g = sample();
      e = sb.pop_front();
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL reset_mid_wait step %0d: got %s expected %s", i, fmt(g), fmt(e));
      end
    end
  endtask

  initial begin
    clk = 1'b0;
    apply(idle());
    test_reset();
    test_branch();
    test_jump_priority();
    test_jr_misaligned();
    test_stall_wait();
    test_wrap();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
